// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC cycle,
// with a bus watchdog that ends stalled strobes with a one-cycle ERR.
module wb_arbiter_2m #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [ADR_W-1:0]   s_adr_o,
  output logic [DAT_W/8-1:0] s_sel_o,
  output logic [DAT_W-1:0]   s_dat_o,
  input  logic [DAT_W-1:0]   s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  output logic [1:0]         gnt
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state, state_nx;
  logic             last, last_nx;   // master that owned the bus most recently
  logic [CNT_W-1:0] to_cnt;
  logic             to_err;
  logic             own0, own1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nx = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nx = GNT0;
        else if (m1_cyc_i)        state_nx = GNT1;
      end
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_sel_o = m0_sel_i;
        s_dat_o = m0_dat_i;
        if (!m0_cyc_i) begin
          last_nx  = 1'b0;
          state_nx = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_sel_o = m1_sel_i;
        s_dat_o = m1_dat_i;
        if (!m1_cyc_i) begin
          last_nx  = 1'b1;
          state_nx = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Watchdog counts stalled strobe cycles of the current owner only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (TIMEOUT == 0 || state_nx != state || !s_stb_o || s_ack_i || s_err_i) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
      to_cnt <= '0;
      to_err <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
      to_err <= 1'b0;
    end
  end

  assign own0     = (state == GNT0);
  assign own1     = (state == GNT1);
  assign gnt      = {own1, own0};
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  // A late ack landing on the watchdog cycle masks the forced error.
  assign m0_err_o = own0 & (s_err_i | (to_err & ~s_ack_i));
  assign m1_err_o = own1 & (s_err_i | (to_err & ~s_ack_i));

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized traffic, every
// cycle compared against an ownership/stall-count reference model.
module tb_wb_arbiter_2m;
  localparam int TO = 16;

  logic        clk, reset;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr [2];
  logic [3:0]  sel [2];
  logic [31:0] wdat [2];
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: current owner (-1 none), last owner, stalled strobe cycles
  int own   = -1;
  int last  = 1;
  int stall = 0;

  wb_arbiter_2m #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]),
    .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]),
    .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_owner();
    if (own < 0) begin
      if (cyc == 2'b11) return 1 - last;
      if (cyc[0]) return 0;
      if (cyc[1]) return 1;
      return -1;
    end
    if (cyc[own]) return own;
    return cyc[1-own] ? 1 - own : -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      own   <= -1;
      last  <= 1;
      stall <= 0;
    end else begin
      if (own >= 0 && !cyc[own]) last <= own;
      if (next_owner() != own)                                  stall <= 0;
      else if (own >= 0 && stb[own] && !s_ack_i && !s_err_i)   stall <= stall + 1;
      else                                                      stall <= 0;
      own <= next_owner();
    end
  end

  task automatic check_cycle();
    logic [127:0] eb;
    logic [3:0]   eae;
    logic [1:0]   eg;
    logic         due;
    eb  = '0;
    eae = '0;
    eg  = '0;
    if (own >= 0) begin
      eg[own]    = 1'b1;
      eb         = {cyc[own], stb[own], we[own], adr[own], sel[own], wdat[own]};
      due        = (stall != 0) && (stall % TO == 0);
      eae[own]   = s_ack_i;
      eae[2+own] = s_err_i | (due & ~s_ack_i);
    end
    check_eq("gnt", gnt, eg);
    check_eq("sbus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o}, eb);
    check_eq("ackerr", {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o}, eae);
    check_eq("rdat", {m1_dat_o, m0_dat_o}, {s_dat_i, s_dat_i});
  endtask

  initial forever begin
    @(negedge clk);
    check_cycle();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic c, input logic s, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    cyc[i]  = c;
    stb[i]  = s;
    we[i]   = w;
    adr[i]  = a;
    wdat[i] = d;
    sel[i]  = 4'hF;
  endtask

  task automatic do_reset();
    set_master(0, 0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0, 0);
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    reset   = 1'b0;
    tick();
    reset   = 1'b1;
  endtask

  int         acks [2];
  int         beats, n1, err_at, n_err;
  logic [1:0] ackd, prev;
  logic       r, quiet;
  logic [1:0] gseq [$];

  initial begin
    reset   = 1'b0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = 32'h1234_5678;
    set_master(0, 1, 1, 0, 32'h10, 32'h11);
    set_master(1, 0, 0, 0, 0, 0);
    tick();
    #1 check_eq("rst_idle", {gnt, s_cyc_o, s_stb_o, m0_ack_o}, '0);
    tick();
    reset = 1'b1;

    // single m1 write, slave acks two cycles after strobe
    do_reset();
    set_master(1, 1, 1, 1, 32'h4000_0000, 32'hDEAD_BEEF);
    #1 check_eq("t1_req_lat", s_cyc_o, 1'b0);
    tick();
    #1 check_eq("t1_cyc", {s_cyc_o, s_stb_o, s_we_o, gnt}, 5'b11110);
    check_eq("t1_adr", s_adr_o, 32'h4000_0000);
    check_eq("t1_dat", s_dat_o, 32'hDEAD_BEEF);
    tick();
    tick();
    s_ack_i = 1'b1;
    #1 check_eq("t1_ack", {m0_ack_o, m1_ack_o}, 2'b01);
    tick();
    s_ack_i = 1'b0;
    set_master(1, 0, 0, 0, 0, 0);
    #1 check_eq("t1_ack_end", m1_ack_o, 1'b0);
    tick();

    // simultaneous request after reset, then back-to-back handover
    do_reset();
    set_master(0, 1, 1, 0, 32'h100, 32'hA);
    set_master(1, 1, 1, 1, 32'h200, 32'hB);
    tick();
    #1 check_eq("t2_first", gnt, 2'b01);
    tick();
    set_master(0, 0, 0, 0, 0, 0);
    #1 check_eq("t2_hold", gnt, 2'b01);
    tick();
    #1 check_eq("t2_handover", gnt, 2'b10);
    set_master(1, 0, 0, 0, 0, 0);
    tick();

    // both masters keep requesting four single transfers each
    do_reset();
    acks[0] = 0;
    acks[1] = 0;
    ackd    = 2'b00;
    prev    = 2'b00;
    gseq.delete();
    for (int c = 0; c < 80 && (acks[0] < 4 || acks[1] < 4); c++) begin
      for (int i = 0; i < 2; i++) begin
        r = !ackd[i] && acks[i] < 4;
        set_master(i, r, r, 1'b0, 32'h300 + i, 32'(c));
      end
      #1 s_ack_i = s_stb_o;
      #1 ackd = {m1_ack_o, m0_ack_o};
      acks[0] += int'(m0_ack_o);
      acks[1] += int'(m1_ack_o);
      if (gnt != 2'b00 && gnt != prev) begin
        gseq.push_back(gnt);
        prev = gnt;
      end
      tick();
    end
    s_ack_i = 1'b0;
    set_master(0, 0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0, 0);
    check_eq("t3_acks0", acks[0], 4);
    check_eq("t3_acks1", acks[1], 4);
    check_eq("t3_nseq", gseq.size(), 8);
    foreach (gseq[k]) check_eq("t3_seq", gseq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    tick();

    // watchdog: m0 read never acknowledged
    do_reset();
    set_master(0, 1, 1, 0, 32'h500, 32'h0);
    tick();
    err_at = -1;
    n_err  = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 3) set_master(1, 1, 1, 0, 32'h600, 32'h0);
      #1 if (m0_err_o) begin
        n_err++;
        if (err_at < 0) err_at = k;
      end
    end
    check_eq("t4_err_at", err_at, 16);
    check_eq("t4_pulses", n_err, 1);
    check_eq("t4_hold", {gnt, s_cyc_o}, 3'b011);
    tick();
    set_master(0, 0, 0, 0, 0, 0);
    tick();
    #1 check_eq("t4_free", gnt, 2'b10);
    set_master(1, 0, 0, 0, 0, 0);
    tick();

    // asynchronous reset while m1 owns the bus mid-strobe
    do_reset();
    set_master(1, 1, 1, 1, 32'h700, 32'h77);
    tick();
    #1 check_eq("t5_pre", gnt, 2'b10);
    s_ack_i = 1'b1;
    #1 reset = 1'b0;
    #1 check_eq("t5_async", {s_cyc_o, s_stb_o, m1_ack_o, gnt}, '0);
    s_ack_i = 1'b0;
    set_master(0, 1, 1, 0, 32'h800, 32'h88);
    tick();
    reset = 1'b1;
    tick();
    #1 check_eq("t5_tie", gnt, 2'b01);
    set_master(0, 0, 0, 0, 0, 0);
    set_master(1, 0, 0, 0, 0, 0);
    tick();

    // m0 three-beat burst must not be preempted by m1
    do_reset();
    set_master(0, 1, 1, 0, 32'h900, 32'h0);
    tick();
    set_master(1, 1, 1, 0, 32'hA00, 32'h0);
    beats = 0;
    n1    = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      #1 s_ack_i = s_stb_o;
      #1 beats += int'(m0_ack_o);
      n1 += int'(m1_ack_o);
      check_eq("t6_gnt", gnt, 2'b01);
      tick();
    end
    s_ack_i = 1'b0;
    set_master(0, 0, 0, 0, 0, 0);
    check_eq("t6_beats", beats, 3);
    check_eq("t6_m1_acks", n1, 0);
    tick();
    #1 check_eq("t6_after", gnt, 2'b10);
    set_master(1, 0, 0, 0, 0, 0);
    tick();

    // randomized traffic with periodic ack-free windows and one async reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      quiet = (c % 300) >= 240;
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) cyc[i] = ($urandom_range(99) < (quiet ? 98 : 88));
        else        cyc[i] = ($urandom_range(99) < 25);
        stb[i]  = cyc[i] && (quiet || $urandom_range(3) != 0);
        we[i]   = 1'($urandom);
        adr[i]  = $urandom;
        sel[i]  = 4'($urandom);
        wdat[i] = $urandom;
      end
      s_dat_i = $urandom;
      s_ack_i = !quiet && ($urandom_range(99) < 30);
      s_err_i = !quiet && ($urandom_range(99) < 6);
      reset   = (c != 1500);
      tick();
    end
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
